// File: rtl/fft_reorder_out.sv
// FFT output reorder: bit-reversed in, natural order out, 1/N on inverse.
// Optional: define FFT_REORDER_ROUND_EN for round-half-up inverse scaling.
module fft_reorder_out #(
  parameter int LOG2N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_inv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]      mem [N];
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic [LOG2N-1:0] rd_nx;
  logic             inv_q;
  logic             in_hs;
  logic             out_hs;
  logic             wr_last;
  logic             rd_last;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // 17-bit headroom keeps the rounding add from overflowing.
  function automatic logic [15:0] scale_c(
    input logic [15:0] c
  );
    logic signed [16:0] s;
    s = signed'({c[15], c});
`ifdef FFT_REORDER_ROUND_EN
    s = s + 17'(1 << (LOG2N - 1));
`endif
    s = s >>> LOG2N;
    return s[15:0];
  endfunction

  function automatic logic [31:0] scale(
    input logic [31:0] w,
    input logic        inv
  );
    if (inv) begin
      return {scale_c(w[31:16]), scale_c(w[15:0])};
    end
    return w;
  endfunction

  assign in_hs   = in_valid & in_ready;
  assign out_hs  = out_valid & out_ready;
  assign wr_last = (wr_cnt == CNT_MAX);
  assign rd_last = (rd_cnt == CNT_MAX);
  assign rd_nx   = rd_cnt + LOG2N'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_hs) state_nx = FILL;
      end
      FILL: begin
        if (in_hs && wr_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state != DRAIN);
    busy     = (state != IDLE);
  end

  // Bit-reversed write into the frame buffer.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem[bitrev(wr_cnt)] <= in_data;
    end
  end

  // Write counter and per-frame inverse flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      inv_q  <= 1'b0;
    end else if (in_hs) begin
      wr_cnt <= wr_cnt + LOG2N'(1);
      if (state == IDLE) begin
        inv_q <= in_inv;
      end
    end
  end

  // Registered natural-order read; word 0 is preloaded as the fill ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_hs && wr_last) begin
      rd_cnt    <= '0;
      out_valid <= 1'b1;
      out_data  <= scale(mem[0], inv_q);
      out_last  <= 1'b0;
    end else if (out_hs) begin
      if (rd_last) begin
        rd_cnt    <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end else begin
        rd_cnt   <= rd_nx;
        out_data <= scale(mem[rd_nx], inv_q);
        out_last <= (rd_nx == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_out.sv
// Randomized bench for fft_reorder_out against an arithmetic model.
// Honours FFT_REORDER_ROUND_EN the same way as the design build.
module tb_fft_reorder_out;

  localparam int L = 4;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int errs = 0;
  int checks = 0;

  logic [31:0] fin [N];
  logic [31:0] exp_q [N];

  fft_reorder_out #(.LOG2N(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int j);
    int r;
    r = 0;
    for (int i = 0; i < L; i++) begin
      if (((j >> i) & 1) != 0) r += 1 << (L - 1 - i);
    end
    return r;
  endfunction

  // Divide by N with floor semantics (optionally +N/2 first).
  function automatic logic [15:0] sc(input logic [15:0] c);
    int t;
    int q;
    t = $signed(c);
`ifdef FFT_REORDER_ROUND_EN
    t = t + N / 2;
`endif
    q = t / N;
    if (t < 0 && (t % N) != 0) q = q - 1;
    return 16'(q);
  endfunction

  task automatic model(input logic inv);
    logic [31:0] w;
    for (int m = 0; m < N; m++) begin
      w = fin[brev(m)];
      exp_q[m] = inv ? {sc(w[31:16]), sc(w[15:0])} : w;
    end
  endtask

  task automatic run_frame(
    input logic inv,
    input bit   tog,
    input int   gap_at,
    input int   stall_at
  );
    int  m;
    int  cyc;
    bit  stalled;
    model(inv);
    for (int j = 0; j < N; j++) begin
      if (j == gap_at) begin
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_ov", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = fin[j];
      in_inv   = (j == 0) ? inv : (tog ? (inv ^ j[0]) : inv);
      chk("fill_ready", 32'(in_ready), 32'd1);
      chk("fill_ov", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_inv   = 1'b0;
    in_data  = $urandom;
    chk("ov_rise", 32'(out_valid), 32'd1);
    m = 0;
    cyc = 0;
    stalled = 0;
    while (m < N && cyc < 200) begin
      cyc++;
      if (m == stall_at && !stalled) begin
        stalled = 1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_data", out_data, exp_q[m]);
          chk("stall_ov", 32'(out_valid), 32'd1);
          chk("stall_ready", 32'(in_ready), 32'd0);
        end
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_data", out_data, exp_q[m]);
      chk("out_last", 32'(out_last), 32'(m == N - 1));
      chk("drain_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      m++;
    end
    if (m < N) chk("drain_timeout", 32'(m), 32'(N));
    chk("end_ov", 32'(out_valid), 32'd0);
    chk("end_last", 32'(out_last), 32'd0);
    chk("end_ready", 32'(in_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic ramp();
    for (int j = 0; j < N; j++) fin[j] = {16'(j), 16'h0000};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_ov", 32'(out_valid), 32'd0);
    chk("idle_last", 32'(out_last), 32'd0);
    chk("idle_data", out_data, 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    ramp();
    run_frame(1'b0, 0, -1, -1);

    for (int j = 0; j < N; j++) fin[j] = 32'h0100FF00;
    run_frame(1'b1, 1, -1, -1);

    for (int j = 0; j < N; j++) fin[j] = 32'h0018FFE8;
    run_frame(1'b1, 0, -1, -1);

    for (int j = 0; j < N; j++) fin[j] = $urandom;
    run_frame(1'b0, 0, -1, 5);

    for (int j = 0; j < 7; j++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_inv   = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    in_inv = 1'b0;
    @(negedge clk);
    ramp();
    run_frame(1'b0, 0, -1, -1);

    ramp();
    run_frame(1'b0, 0, 4, -1);

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < N; j++) fin[j] = $urandom;
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, N + 3), $urandom_range(0, N + 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fft_reorder_out.md
# fft_reorder_out

Output stage of the streaming FFT/IFFT datapath. Frames leave the in-place butterfly array in bit-reversed order. This block buffers one N-point frame, emits it in natural order, and for inverse frames applies the 1/N scaling. Data uses the butterfly word format: {re[31:16], im[15:0]}, signed Q8.8 per component.

## Interface
- `LOG2N`, default 4: log2 of frame length; N = 2^LOG2N points, legal range 2..10.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_data` holds a valid word.
- `in_ready`  out  1  block accepts an input word this cycle.
- `in_data`  in  32  input word, bit-reversed stream order.
- `in_inv`  in  1  frame is inverse transform; sampled with the first word of each frame only.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `out_data`  out  32  output word, natural order.
- `out_last`  out  1  high with the final word (index N-1) of a frame.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Buffer: N×32 register array. Write counter `wr_cnt` and read counter `rd_cnt` are each LOG2N bits wide. Inverse flag register `inv_q`.
- States and transitions:
  - IDLE → FILL on the first input handshake. That handshake writes the word and captures `in_inv` into `inv_q`.
  - FILL → DRAIN on the handshake that writes word N-1.
  - DRAIN → IDLE on the output handshake with `out_last` = 1.
- Write rule: input handshake j writes `mem[bitrev(j)]`, where bitrev reverses the LOG2N-bit index. `wr_cnt` increments and wraps to 0 after N-1.
- Read rule: output index m presents `mem[m]` after scaling. `rd_cnt` advances on each output handshake and wraps to 0 after N-1.
- Handshake: a transfer occurs when `valid` and `ready` are both high on a rising edge.
  - `in_ready` = 1 in IDLE and FILL, 0 in DRAIN.
  - While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_last` hold stable.
  - Input and output do not overlap; there is one frame in flight.
- Scaling when `inv_q` = 1:
  - Each component is sign-extended to 17 bits, optionally rounded (see Configuration), then arithmetic-shifted right by LOG2N and truncated to 16 bits.
  - The result cannot overflow.
  - When `inv_q` = 0, data passes unmodified.
- `in_inv` is ignored on every word except the first of a frame.
- Reset values, mid-operation included:
  - State IDLE; `wr_cnt`, `rd_cnt`, `inv_q` = 0.
  - `in_ready` = 1; `out_valid` = 0, `out_last` = 0, `out_data` = 0, `busy` = 0.
  - A partial frame is discarded. Buffer contents are don't-care.

## Timing
- `out_data`, `out_valid`, and `out_last` are registered.
- `out_valid` rises the cycle after the handshake that writes word N-1. The first output word is available then.
- Throughput: one output word per cycle while `out_ready` = 1.
- `in_ready` returns to 1 the cycle after the final output handshake.
- Minimum frame period: 2N cycles under no backpressure.
- `in_valid` low during FILL stalls the fill; no state or counter changes.

## Configuration
- `FFT_REORDER_ROUND_EN` defined:
  - Inverse scaling rounds half-up: add 2^(LOG2N-1) in 17-bit arithmetic before the shift.
  - Example: -24 >> 4 gives -1.
- `FFT_REORDER_ROUND_EN` undefined:
  - Plain arithmetic shift, which truncates toward −∞.
  - Example: -24 >> 4 gives -2.
- Forward frames are unaffected in both builds.

## Test plan
- Forward reorder, LOG2N=4:
  - Stimulus: input word j = {j, 0x0000} for j = 0..15, `in_inv` = 0, `out_ready` = 1.
  - Required: out re sequence 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15.
  - Required: `out_last` only on the 16th word; `out_valid` rises 1 cycle after input word 15.
- Inverse scaling:
  - Stimulus: all 16 inputs = 0x0100FF00 (1.0, −1.0), `in_inv` = 1 on word 0.
  - Required: every output = 0x0010FFF0.
  - Stimulus: `in_inv` toggling on words 1..15.
  - Required: no effect.
- Rounding:
  - Stimulus: inverse frame with word re = 0x0018, im = 0xFFE8.
  - Required with macro: 0x0002FFFF.
  - Required without macro: 0x0001FFFE.
- Backpressure:
  - Stimulus: `out_ready` held low for 3 cycles at output m = 5.
  - Required: `out_data` stable through the stall; no word dropped or duplicated.
  - Required: `in_ready` = 0 throughout DRAIN.
- Reset mid-fill:
  - Stimulus: assert `rst` asynchronously after 7 input words.
  - Required: immediately `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - Required: the next full forward frame reorders correctly, identical to the first scenario.
- Input gaps:
  - Stimulus: `in_valid` deasserted for 2 cycles between words 3 and 4.
  - Required: output identical to the gap-free run.
